// File: rtl/ipsum_fetch_fifo_if.sv
// Port bundle for the psum fetch FIFO: tile control, GLB read channel and psum pop channel.
// master is the fetch FIFO side; slave is the controller / GLB / consumer side.
interface ipsum_fetch_fifo_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned CNT_OUT_W = $clog2(DEPTH) + 1;

  logic                 start;
  logic [ADDR_W-1:0]    base_addr;
  logic [CNT_W-1:0]     num_psum;
  logic                 busy;
  logic                 done;
  logic                 glb_rd_en;
  logic [ADDR_W-1:0]    glb_addr;
  logic [31:0]          glb_rdata;
  logic                 pop_en;
  logic [15:0]          pop_data;
  logic                 empty;
  logic                 full;
  logic [CNT_OUT_W-1:0] count;

  modport master (
    input  start, base_addr, num_psum, glb_rdata, pop_en,
    output busy, done, glb_rd_en, glb_addr, pop_data, empty, full, count
  );

  modport slave (
    output start, base_addr, num_psum, glb_rdata, pop_en,
    input  busy, done, glb_rd_en, glb_addr, pop_data, empty, full, count
  );
endinterface

// File: rtl/ipsum_fetch_fifo.sv
// Fetches packed 32-bit psum words from the GLB, splits each into two 16-bit psums
// (low half first) and buffers them for single-psum pops; one tile per start.
module ipsum_fetch_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  ipsum_fetch_fifo_if.master bus
);
  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned CNT_OUT_W = PTR_W + 1;
  localparam int unsigned SPACE_W   = CNT_OUT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    addr_q;
  logic [CNT_W-1:0]     words_left, wr_left, pop_left;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_OUT_W-1:0] count;
  logic                 rd_valid;
  logic [15:0]          mem [DEPTH];

  logic                 issue_c, pop_c, wr_two_c, wr_one_c, last_pop_c;
  logic [1:0]           wr_n_c;
  logic [SPACE_W-1:0]   need_c;
  logic [CNT_W:0]       words_init_c;
  logic [PTR_W-1:0]     wr_ptr_p1_c;

  // Issue only if the buffer can absorb this word on top of what is stored and in flight.
  assign need_c       = SPACE_W'(count) + (rd_valid ? SPACE_W'(4) : SPACE_W'(2));
  assign issue_c      = (state == S_FETCH) && (words_left != '0) && (need_c <= SPACE_W'(DEPTH));
  assign pop_c        = bus.pop_en && (count != '0);
  assign last_pop_c   = pop_c && (pop_left == CNT_W'(1));
  assign wr_two_c     = rd_valid && (wr_left >= CNT_W'(2));
  assign wr_one_c     = rd_valid && (wr_left == CNT_W'(1));
  assign wr_n_c       = wr_two_c ? 2'd2 : (wr_one_c ? 2'd1 : 2'd0);
  assign words_init_c = ({1'b0, bus.num_psum} + (CNT_W + 1)'(1)) >> 1;
  assign wr_ptr_p1_c  = wr_ptr + PTR_W'(1);

  assign bus.glb_addr = addr_q;
  assign bus.pop_data = (count != '0) ? mem[rd_ptr] : 16'd0;
  assign bus.empty    = (count == '0);
  assign bus.full     = (count == CNT_OUT_W'(DEPTH));
  assign bus.count    = count;

  // Tile sequencing: next state and state-decoded outputs.
  always_comb begin
    state_nxt     = state;
    bus.busy      = (state != S_IDLE);
    bus.done      = (state == S_DONE);
    bus.glb_rd_en = issue_c;
    unique case (state)
      S_IDLE:  if (bus.start) state_nxt = (bus.num_psum == '0) ? S_DONE : S_FETCH;
      S_FETCH: if (issue_c && (words_left == CNT_W'(1))) state_nxt = S_DRAIN;
      S_DRAIN: if ((pop_left == '0) || last_pop_c) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      words_left <= '0;
      wr_left    <= '0;
      pop_left   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_valid   <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_valid <= issue_c;
      if ((state == S_IDLE) && bus.start) begin
        addr_q     <= bus.base_addr;
        words_left <= CNT_W'(words_init_c);
        wr_left    <= bus.num_psum;
        pop_left   <= bus.num_psum;
      end else begin
        if (issue_c) begin
          addr_q     <= addr_q + ADDR_W'(4);
          words_left <= words_left - CNT_W'(1);
        end
        if (wr_two_c)      wr_left <= wr_left - CNT_W'(2);
        else if (wr_one_c) wr_left <= wr_left - CNT_W'(1);
        if (pop_c)         pop_left <= pop_left - CNT_W'(1);
      end
      if (wr_two_c)      wr_ptr <= wr_ptr + PTR_W'(2);
      else if (wr_one_c) wr_ptr <= wr_ptr_p1_c;
      if (pop_c)         rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_OUT_W'(wr_n_c) - CNT_OUT_W'(pop_c);
    end
  end

  // Storage is not reset; a return arriving during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && (wr_two_c || wr_one_c)) mem[wr_ptr]      <= bus.glb_rdata[15:0];
    if (!rst && wr_two_c)               mem[wr_ptr_p1_c] <= bus.glb_rdata[31:16];
  end
endmodule

// File: doc/ipsum_fetch_fifo.md
Name: ipsum_fetch_fifo

Overview:
Read-side counterpart of the opsum packing FIFO. It fetches packed 32-bit partial-sum words from the GLB, unpacks each word into two 16-bit psums (low half first), and buffers them for single-psum pops by the PE array / adder chain. A start/done FSM sequences one tile of N psums and throttles GLB reads so buffer space is never exceeded.

Parameters:
DEPTH, 4, FIFO entries of 16 bits; power of two, at least 4.
ADDR_W, 32, GLB byte-address width.
CNT_W, 16, width of the psum count.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; latches base_addr and num_psum when idle
base_addr  in  ADDR_W  byte address of the first packed word (4-byte aligned)
num_psum  in  CNT_W  number of 16-bit psums in the tile
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the last psum has been popped
glb_rd_en  out  1  GLB read request, one 32-bit word
glb_addr  out  ADDR_W  byte address of the request
glb_rdata  in  32  read data, valid exactly 1 cycle after glb_rd_en
pop_en  in  1  consumer pops one psum
pop_data  out  16  head psum (combinational); 0 when empty
empty  out  1  count == 0
full  out  1  count == DEPTH
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (sync, rst=1 at posedge): FSM to IDLE; wr_ptr, rd_ptr, count, all counters and rd_valid pipe reg cleared; busy=0, done=0, glb_rd_en=0, glb_addr=0. Storage array is not reset. Reset mid-fetch discards any in-flight return: glb_rdata in the cycle after reset is ignored.
- FSM states: IDLE, FETCH, DRAIN, DONE.
  - IDLE: start=1 latches addr, words_left=ceil(num_psum/2), wr_left=num_psum, pop_left=num_psum. Next state is FETCH, or DONE if num_psum=0.
  - FETCH: issue reads. Go to DRAIN the cycle after the last request is issued.
  - DRAIN: wait until pop_left reaches 0, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- busy = (state != IDLE).
- Read issue rule in FETCH: glb_rd_en=1 when words_left>0 and (DEPTH - count - 2*rd_valid) >= 2.
  - rd_valid is the 1-cycle-delayed glb_rd_en.
  - The rule counts space freed by a same-cycle pop only from the next cycle (conservative).
- glb_addr increments by 4 after each issued request. words_left decrements on each issue.
- Return write, in the cycle rd_valid=1:
  - If wr_left >= 2: mem[wr_ptr] <= glb_rdata[15:0], mem[wr_ptr+1] <= glb_rdata[31:16]; wr_ptr += 2; wr_left -= 2.
  - If wr_left == 1 (odd tail): write only the low half; upper half discarded; wr_ptr += 1.
  - Pointers wrap modulo DEPTH.
- Pop: pop_en && !empty advances rd_ptr by 1 and decrements pop_left. pop_en when empty is ignored, with no state change.
- pop_data = mem[rd_ptr] when !empty, else 16'd0.
- Count update per cycle: count_next = count + written(0/1/2) - popped(0/1).
  - Simultaneous 2-write and 1-pop gives net +1.
  - The issue rule guarantees count never exceeds DEPTH. Overflow is a design error; an assertion is required in the bench.
- Latency: first psum poppable 2 cycles after the first glb_rd_en (request cycle, then write cycle).
- done asserts the cycle after the pop that takes pop_left to 0.

Test Plan:
- Even tile: base_addr=0x100, num_psum=4, GLB words {0xBBBB_AAAA, 0xDDDD_CCCC}, pop_en held high -> glb_addr 0x100, 0x104; pops AAAA, BBBB, CCCC, DDDD; done pulses once; busy falls the cycle after.
- Odd tail: num_psum=3, words {0x0002_0001, 0xFFFF_0003} -> pops 0001, 0002, 0003; 0xFFFF never appears; exactly 2 reads issued; count returns to 0.
- Backpressure: DEPTH=4, num_psum=10, pop_en=0 for 20 cycles -> exactly 2 reads issued, full=1, count=4, no further glb_rd_en. Releasing pop_en resumes reads; all 10 psums popped in order with no loss.
- Simultaneous write and pop: count=1, return write of 2 coincides with a pop -> count=2 next cycle, pointers consistent across wrap (wr_ptr 3->1).
- Corner inputs: num_psum=0 start -> no glb_rd_en, done pulse 1 cycle after IDLE->DONE. start while busy -> ignored, latched params unchanged. pop_en on empty -> pop_data=0, count stays 0.
- Reset mid-fetch: rst asserted the cycle a read is in flight -> next cycle state IDLE, count=0, empty=1; the returning glb_rdata is not written. A new start then completes normally.
